// File: rtl/mem_port_arbiter_if.sv
// Bundle of upstream request ports, downstream controller port and watchdog
// status for mem_port_arbiter. slave = arbiter side, master = environment.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Instruction fetch port
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ack;

    // Data port
    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ack;

    // SDRAM controller core request interface
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    // Watchdog status
    logic                  err;
    logic                  err_port;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_addr, d_wdata, d_we, d_be,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ack,
        output d_rdata, d_ack,
        output mem_req, mem_addr, mem_wdata, mem_we, mem_be,
        output err, err_port
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_addr, d_wdata, d_we, d_be,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ack,
        input  d_rdata, d_ack,
        input  mem_req, mem_addr, mem_wdata, mem_we, mem_be,
        input  err, err_port
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging the instruction-fetch and data ports onto one
// SDRAM controller request interface, with a sticky ack watchdog.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_ack_q, d_ack_d;
    logic [31:0]           wd_q, wd_d;
    logic                  err_q, err_d;
    logic                  err_port_q, err_port_d;

    logic                  pick;
    logic [31:0]           wd_inc;

    assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        if_ack_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_ack_d     = 1'b0;
        wd_d        = wd_q;
        err_d       = err_q;
        err_port_d  = err_port_q;
        pick        = PORT_IF;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie the port not granted last wins
                    if (bus.if_req && bus.d_req) pick = ~last_q;
                    else                         pick = bus.d_req;

                    if (pick == PORT_D) begin
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_we_d    = bus.d_we;
                        mem_be_d    = bus.d_be;
                    end else begin
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hF;
                    end
                    gnt_d     = pick;
                    last_d    = pick;
                    mem_req_d = 1'b1;
                    wd_d      = '0;
                    state_d   = BUSY;
                end
            end

            BUSY: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (gnt_q == PORT_D) begin
                        d_rdata_d = bus.mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    wd_d = wd_inc;
                    // Flag only; the transaction keeps waiting for its ack
                    if ((TIMEOUT_CYCLES != 0) && (wd_inc == TIMEOUT_CYCLES) && !err_q) begin
                        err_d      = 1'b1;
                        err_port_d = gnt_q;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= PORT_IF;
            last_q      <= PORT_D;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            err_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_ack_q    <= if_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_ack_q     <= d_ack_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            err_port_q  <= err_port_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.err_port  = err_port_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written contention, back-to-back, watchdog and reset sequences.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_fail;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned delay;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {bus.if_rdata, bus.if_ack, bus.d_rdata, bus.d_ack, bus.mem_req,
                bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_be, bus.err, bus.err_port};
    endfunction

    function automatic logic [159:0] mem_fields();
        return {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_we      = 1'b0;
        bus.d_be      = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [159:0] exp_fields;
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
            bus.d_we = v.we; bus.d_be = v.be;
        end else begin
            // Junk on the idle data port must not leak into an instruction grant
            bus.if_req = 1'b1; bus.if_addr = v.addr;
            bus.d_we = 1'b1; bus.d_be = 4'h0; bus.d_wdata = 32'hDEAD_DEAD;
        end
        tick();
        exp_fields = {1'b1, v.exp_we, v.exp_be, v.addr, v.exp_wdata};
        check({v.name, " grant"}, mem_fields(), exp_fields);
        for (int unsigned k = 1; k < v.delay; k++) begin
            tick();
            check({v.name, " stable"}, mem_fields(), exp_fields);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5555_5555;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        if (v.is_d) exp_d_rdata = v.rdata;
        else        exp_if_rdata = v.rdata;
        check({v.name, " acks"}, {bus.mem_req, bus.if_ack, bus.d_ack}, {1'b0, ~v.is_d, v.is_d});
        check({v.name, " rdata"}, {bus.if_rdata, bus.d_rdata}, {exp_if_rdata, exp_d_rdata});
        tick();
        check({v.name, " ack pulse"}, {bus.mem_req, bus.if_ack, bus.d_ack, bus.err}, 4'b0000);
        bus.d_we = 1'b0; bus.d_be = '0; bus.d_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned lows;
        logic        exp_port;
        logic [31:0] ia, da;

        n_checks = 0;
        n_fail   = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;

        //           name       is_d we    be     addr           wdata          rdata          D  eWe   eBe    eWdata
        vecs[0] = '{"if_read",  1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 5, 1'b0, 4'hF, 32'h0};
        vecs[1] = '{"d_write",  1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'h1234_5678, 32'h0BAD_0001, 3, 1'b1, 4'h3, 32'h1234_5678};
        vecs[2] = '{"d_read",   1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0,         32'hA5A5_5A5A, 1, 1'b0, 4'hF, 32'h0};
        vecs[3] = '{"if_read2", 1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0,         32'h0BAD_BEEF, 2, 1'b0, 4'hF, 32'h0};
        vecs[4] = '{"d_wr_hi",  1'b1, 1'b1, 4'h8, 32'hFFFF_FFFC, 32'h89AB_CDEF, 32'h0000_0000, 4, 1'b1, 4'h8, 32'h89AB_CDEF};

        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset outputs", all_outs(), '0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // mem_ack outside BUSY is ignored
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        check("stray ack", {bus.mem_req, bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata},
              {3'b000, exp_if_rdata, exp_d_rdata});

        // Contention from reset: IF, D, IF, D
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ia = 32'h200; da = 32'h300;
        bus.if_req = 1'b1; bus.if_addr = ia;
        bus.d_req = 1'b1; bus.d_addr = da; bus.d_we = 1'b0; bus.d_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            exp_port = (i % 2 == 1);
            tick();
            check("cont grant", {bus.mem_req, bus.mem_addr}, {1'b1, exp_port ? da : ia});
            tick();
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + 32'(i);
            tick();
            bus.mem_ack = 1'b0;
            check("cont ack", {bus.if_ack, bus.d_ack}, {~exp_port, exp_port});
            check("cont rdata", exp_port ? bus.d_rdata : bus.if_rdata, 32'h1000 + 32'(i));
            if (exp_port) begin da += 4; bus.d_addr = da; end
            else          begin ia += 4; bus.if_addr = ia; end
            tick();
        end
        idle_inputs();
        tick();

        // Back-to-back on the instruction port with req held across the ack
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        tick();
        check("b2b first", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h400});
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_0000;
        tick();
        bus.mem_ack = 1'b0;
        bus.if_addr = 32'h404;
        lows = 0;
        while (!bus.mem_req && lows < 10) begin
            lows++;
            tick();
        end
        check("b2b gap", 32'(lows), 32'd2);
        check("b2b second", {bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be},
              {1'b1, 32'h404, 1'b0, 4'hF});
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_0004;
        tick();
        bus.mem_ack = 1'b0; bus.if_req = 1'b0;
        check("b2b ack", {bus.if_ack, bus.if_rdata}, {1'b1, 32'h7777_0004});
        tick();

        // Watchdog: D write held 20 cycles without ack
        check("wd pre err", {bus.err, bus.err_port}, 2'b00);
        bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = 32'hABCD_0123;
        bus.d_we = 1'b1; bus.d_be = 4'hC;
        tick();
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 7) check("wd not yet", bus.err, 1'b0);
            if (k == 8) check("wd err set", {bus.err, bus.err_port}, 2'b11);
        end
        check("wd stable", mem_fields(), {1'b1, 1'b1, 4'hC, 32'h500, 32'hABCD_0123});
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0;
        tick();
        bus.mem_ack = 1'b0; bus.d_req = 1'b0;
        check("wd complete", {bus.d_ack, bus.mem_req, bus.err, bus.err_port}, 4'b1011);
        tick();
        tick();
        check("wd sticky", {bus.err, bus.err_port}, 2'b11);

        // Asynchronous reset during BUSY
        bus.d_req = 1'b1; bus.d_addr = 32'h600; bus.d_we = 1'b0; bus.d_be = 4'hF;
        tick();
        check("rst busy", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst async", all_outs(), '0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst regrant", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h600});
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h6666_6666;
        tick();
        bus.mem_ack = 1'b0; bus.d_req = 1'b0;
        check("rst done", {bus.d_ack, bus.d_rdata, bus.if_ack}, {1'b1, 32'h6666_6666, 1'b0});
        tick();

        // Tie after reset goes to the instruction port
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h700;
        bus.d_req = 1'b1; bus.d_addr = 32'h800; bus.d_we = 1'b1; bus.d_be = 4'h1;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst tie", {bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be}, {1'b1, 32'h700, 1'b0, 4'hF});
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7070_7070;
        tick();
        bus.mem_ack = 1'b0;
        idle_inputs();
        check("rst tie ack", {bus.if_ack, bus.d_ack, bus.if_rdata}, {2'b10, 32'h7070_7070});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port request arbiter that sits directly upstream of the SDRAM controller and drives its single core request interface. It merges the instruction-fetch port (read-only) and the data port (read/write) using round-robin arbitration. It holds the granted request stable on the controller interface until that request is acknowledged, then returns the read data and a one-cycle ack to the granted requester. A watchdog flags downstream acknowledges that never arrive.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- TIMEOUT_CYCLES, 1024, cycles in BUSY before err asserts; 0 disables the watchdog
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- if_req  in  1  instruction port request, level, held until if_ack
- if_addr  in  ADDR_WIDTH  instruction read address
- if_rdata  out  DATA_WIDTH  instruction read data, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data port request, level, held until d_ack
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  data write data
- d_we  in  1  1 = write, 0 = read
- d_be  in  4  byte enables
- d_rdata  out  DATA_WIDTH  data read data, valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse, data port
- mem_req  out  1  request to the SDRAM controller
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  DATA_WIDTH  latched write data
- mem_we  out  1  latched write enable; always 0 for instruction grants
- mem_be  out  4  latched byte enables; 4'hF for instruction grants
- mem_rdata  in  DATA_WIDTH  controller read data, valid with mem_ack
- mem_ack  in  1  controller completion pulse
- err  out  1  sticky watchdog flag
- err_port  out  1  port granted when err first set (0 = instruction, 1 = data)

## Operation
- FSM has three states, IDLE, BUSY and RESP. Reset state is IDLE.
- Reset values: all outputs 0, and the last-grant pointer is 1, so the first tie goes to the instruction port.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port that was not granted last.
  - On grant:
    - latch addr, wdata, we and be into the mem_* registers; an instruction grant forces we=0 and be=4'hF;
    - record the granted port and update the last-grant pointer;
    - set mem_req=1, clear the watchdog counter, and go to BUSY.
- BUSY:
  - mem_* fields stay constant for the whole state. The controller samples mem_we late, so stability until ack is mandatory.
  - On mem_ack=1: capture mem_rdata into the granted port's rdata register, set mem_req=0 and the granted port's ack=1, then go to RESP.
  - Otherwise increment the watchdog counter, saturating. When it equals TIMEOUT_CYCLES (if nonzero) and err=0, set err=1 and err_port to the granted port. Keep waiting; the transaction is never aborted.
- RESP:
  - The ack is high for exactly this cycle. Clear the ack and return to IDLE.
  - Requests are not sampled in RESP.
- Upstream rule: a requester sees ack, then at the following edge either drops req or presents a new request with new fields. A req still high in IDLE is treated as a new request.
- rdata registers hold their last value until the next ack on that port. A write ack returns mem_rdata as captured; its value is don't-care.
- mem_ack outside BUSY is ignored.
- err clears only on reset.
- Asynchronous reset mid-transaction returns the block to IDLE with mem_req=0 and no ack issued. The requester must re-issue its request.

## Timing
- Grant to mem_req: mem_req is high on the cycle after req is seen in IDLE.
- mem_ack to port ack: the port ack and rdata are registered, so they are high one cycle after mem_ack.
- Total port latency: 1 + D + 1 cycles from req sampled to ack, where D is cycles from mem_req rising to mem_ack.
- mem_req is low for at least 2 cycles between consecutive transactions (RESP plus IDLE). This guarantees the controller sees a deasserted request after its ack.
- Throughput: one transaction per D + 3 cycles under continuous load.
- Under continuous contention, grants alternate strictly between the two ports.

## Test plan
- Instruction read alone: if_req with if_addr=0x100, mem_ack after 5 cycles with mem_rdata=0xCAFEF00D -> mem_we=0, mem_be=F, if_ack is a single pulse with if_rdata=0xCAFEF00D, and d_ack stays 0.
- Data write: d_req, d_we=1, d_be=4'b0011, d_wdata=0x12345678 -> mem_* fields match and stay stable until mem_ack; d_ack is a single pulse; mem_req drops the cycle after mem_ack.
- Contention: both ports request from reset and keep re-requesting -> grant order is IF, D, IF, D; each ack goes only to its own port.
- Back-to-back: if_req held high across an ack with a new address -> a second transaction with the new address; mem_req is low for exactly 2 cycles in between.
- Watchdog: TIMEOUT_CYCLES=8, d port granted, mem_ack withheld 20 cycles -> err=1 and err_port=1 at cycle 8 of BUSY; the transaction completes normally when mem_ack arrives, and err stays 1.
- Reset mid-BUSY: assert rst_n=0 during BUSY -> all outputs 0 immediately; after release, a pending d_req is granted (tie-break favours IF if both are pending).
